// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: encodings, FSM states and size helpers shared by the MEM load/store stage
package mem_lsu_pkg;
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_PC4  = 2'b01;
  localparam logic [1:0] SEL_ALU  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam int BYTE_W  = 8;
  localparam int HALF_W  = 16;
  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
  // log2 of the access size in bytes; doubleword folds to word on a 32-bit datapath
  function automatic logic [1:0] eff_size(input logic [1:0] f3_size, input int xlen);
    return (xlen == 32 && f3_size == 2'b11) ? 2'b10 : f3_size;
  endfunction
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    return (off & ((3'd1 << size) - 3'd1)) != 3'd0;
  endfunction
endpackage

// File: rtl/mem_lsu_stage_load_align.sv
// load_align: extracts the addressed lane from a full read word and sign/zero-extends it
module load_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]   rdata,
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  output logic [XLEN-1:0]   result
);
  logic [XLEN-1:0] s;
  assign s = rdata >> {lane, 3'b000};
  // LWU on a 32-bit datapath behaves as LW, which is the raw word
  assign result = funct3 == F3_LB  ? XLEN'($signed(s[BYTE_W-1:0])) :
                  funct3 == F3_LH  ? XLEN'($signed(s[HALF_W-1:0])) :
                  funct3 == F3_LW  ? XLEN'($signed(s[WORD_W-1:0])) :
                  funct3 == F3_LBU ? XLEN'(s[BYTE_W-1:0]) :
                  funct3 == F3_LHU ? XLEN'(s[HALF_W-1:0]) :
                  funct3 == F3_LWU ? (XLEN == DWORD_W ? XLEN'(s[WORD_W-1:0]) : XLEN'($signed(s[WORD_W-1:0]))) :
                  s;
endmodule

// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: MEM stage issuing load/store requests on a valid/ready channel and waiting for responses
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN
module mem_lsu_stage
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_WIDTH = 32,
  parameter int RADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exe_to_mem_valid,
  output logic                mem_allow_in,
  input  logic                wb_allow_in,
  output logic                mem_to_wb_valid,
  input  logic [PC_WIDTH-1:0] exe_pc,
  input  logic [XLEN-1:0]     exe_alu_result,
  input  logic [XLEN-1:0]     exe_store_data,
  input  logic [1:0]          exe_mem_op,
  input  logic [2:0]          exe_funct3,
  input  logic [1:0]          exe_rf_wr_sel,
  input  logic                exe_rf_wr_en,
  input  logic [RADDR_W-1:0]  exe_reg_waddr,
  input  logic                exe_inst_ebreak,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic                dmem_req_we,
  output logic [XLEN-1:0]     dmem_req_addr,
  output logic [XLEN/8-1:0]   dmem_req_wstrb,
  output logic [XLEN-1:0]     dmem_req_wdata,
  input  logic                dmem_rsp_valid,
  input  logic [XLEN-1:0]     dmem_rsp_rdata,
  output logic [PC_WIDTH-1:0] mem_to_wb_pc,
  output logic [XLEN-1:0]     mem_to_wb_result,
  output logic                mem_to_wb_rf_wr_en,
  output logic [RADDR_W-1:0]  mem_to_wb_reg_waddr,
  output logic                mem_to_wb_ebreak,
  output logic                mem_valid,
  output logic                bypass_wr_en,
  output logic [RADDR_W-1:0]  bypass_waddr,
  output logic [XLEN-1:0]     bypass_data,
  output logic                bypass_busy
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                mem_to_wb_misalign
`endif
);
  localparam int LANE_W = $clog2(XLEN / 8);
  lsu_state_e state, state_n;
  logic [PC_WIDTH-1:0] pc_q, pc_inc;
  logic [XLEN-1:0] alu_q, sd_q, rdata_q, load_data, result;
  logic [1:0] op_q, sel_q, sz;
  logic [2:0] f3_q;
  logic wr_en_q, ebreak_q;
  logic [RADDR_W-1:0] waddr_q;
  logic [LANE_W-1:0] lane;
  logic [XLEN/8-1:0] size_mask;
  logic is_mem, ready_go, cap, cap_mem, entry_mis, mis, wr_en;
  assign is_mem = op_q == MEM_LOAD || op_q == MEM_STORE;
  assign ready_go = !is_mem || state == DONE;
  assign mem_allow_in = !mem_valid || (ready_go && wb_allow_in);
  assign cap = mem_allow_in && exe_to_mem_valid;
  assign cap_mem = cap && (exe_mem_op == MEM_LOAD || exe_mem_op == MEM_STORE);
  assign lane = alu_q[LANE_W-1:0];
  assign sz = eff_size(f3_q[1:0], XLEN);
  assign pc_inc = pc_q + PC_WIDTH'(4);
  assign size_mask = sz == 2'd0 ? 'h1 : sz == 2'd1 ? 'h3 : sz == 2'd2 ? 'hf : '1;
`ifdef MEM_MISALIGN_TRAP_EN
  assign entry_mis = misaligned(3'(exe_alu_result[LANE_W-1:0]), eff_size(exe_funct3[1:0], XLEN));
  assign mis = is_mem && misaligned(3'(lane), sz);
  assign mem_to_wb_misalign = mem_valid && mis;
`else
  assign entry_mis = 1'b0;
  assign mis = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mem_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (mem_allow_in) mem_valid <= exe_to_mem_valid;
    end
  always_ff @(posedge clk) begin
    if (cap) begin
      pc_q <= exe_pc;
      alu_q <= exe_alu_result;
      sd_q <= exe_store_data;
      op_q <= exe_mem_op;
      f3_q <= exe_funct3;
      sel_q <= exe_rf_wr_sel;
      wr_en_q <= exe_rf_wr_en;
      waddr_q <= exe_reg_waddr;
      ebreak_q <= exe_inst_ebreak;
    end
    if (state == WAIT && dmem_rsp_valid) rdata_q <= dmem_rsp_rdata;
  end
  // A misaligned access under the trap skips the bus and completes immediately
  always_comb
    state_n = (state == IDLE || (state == DONE && wb_allow_in)) ? (cap_mem ? (entry_mis ? DONE : REQ) : IDLE) :
              (state == REQ && dmem_req_ready) ? WAIT :
              (state == WAIT && dmem_rsp_valid) ? DONE : state;
  load_align #(.XLEN(XLEN), .LANE_W(LANE_W)) u_align (
    .rdata(rdata_q),
    .funct3(f3_q),
    .lane(lane),
    .result(load_data)
  );
  always_comb begin
    dmem_req_valid = state == REQ;
    dmem_req_we = op_q == MEM_STORE;
    dmem_req_addr = {alu_q[XLEN-1:LANE_W], LANE_W'(0)};
    dmem_req_wstrb = size_mask << lane;
    dmem_req_wdata = sz == 2'd0 ? {XLEN/8{sd_q[7:0]}} : sz == 2'd1 ? {XLEN/16{sd_q[15:0]}} :
                     sz == 2'd2 ? {XLEN/32{sd_q[31:0]}} : sd_q;
    result = mis ? alu_q : sel_q == SEL_ZERO ? '0 : sel_q == SEL_PC4 ? XLEN'(pc_inc) :
             sel_q == SEL_ALU ? alu_q : load_data;
    wr_en = wr_en_q && !mis;
    mem_to_wb_valid = mem_valid && ready_go;
    mem_to_wb_pc = pc_q;
    mem_to_wb_result = result;
    mem_to_wb_rf_wr_en = wr_en;
    mem_to_wb_reg_waddr = waddr_q;
    mem_to_wb_ebreak = ebreak_q;
    bypass_wr_en = mem_valid && wr_en;
    bypass_waddr = waddr_q;
    bypass_data = result;
    bypass_busy = mem_valid && op_q == MEM_LOAD && state != DONE;
  end
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: directed and randomized checks of mem_lsu_stage against a transaction-level model
module tb_mem_lsu_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic exe_to_mem_valid = 1'b0, mem_allow_in, wb_allow_in = 1'b1, mem_to_wb_valid;
  logic [31:0] exe_pc = '0, exe_alu_result = '0, exe_store_data = '0;
  logic [1:0] exe_mem_op = '0, exe_rf_wr_sel = '0;
  logic [2:0] exe_funct3 = '0;
  logic exe_rf_wr_en = 1'b0, exe_inst_ebreak = 1'b0;
  logic [4:0] exe_reg_waddr = '0;
  logic dmem_req_valid, dmem_req_ready = 1'b0, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0] dmem_req_wstrb;
  logic dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic [31:0] mem_to_wb_pc, mem_to_wb_result, bypass_data;
  logic mem_to_wb_rf_wr_en, mem_to_wb_ebreak, mem_valid, bypass_wr_en, bypass_busy;
  logic [4:0] mem_to_wb_reg_waddr, bypass_waddr;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_lsu_stage #(.XLEN(32), .PC_WIDTH(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .exe_to_mem_valid(exe_to_mem_valid), .mem_allow_in(mem_allow_in),
    .wb_allow_in(wb_allow_in), .mem_to_wb_valid(mem_to_wb_valid),
    .exe_pc(exe_pc), .exe_alu_result(exe_alu_result), .exe_store_data(exe_store_data),
    .exe_mem_op(exe_mem_op), .exe_funct3(exe_funct3), .exe_rf_wr_sel(exe_rf_wr_sel),
    .exe_rf_wr_en(exe_rf_wr_en), .exe_reg_waddr(exe_reg_waddr), .exe_inst_ebreak(exe_inst_ebreak),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .mem_to_wb_pc(mem_to_wb_pc), .mem_to_wb_result(mem_to_wb_result),
    .mem_to_wb_rf_wr_en(mem_to_wb_rf_wr_en), .mem_to_wb_reg_waddr(mem_to_wb_reg_waddr),
    .mem_to_wb_ebreak(mem_to_wb_ebreak), .mem_valid(mem_valid),
    .bypass_wr_en(bypass_wr_en), .bypass_waddr(bypass_waddr), .bypass_data(bypass_data),
    .bypass_busy(bypass_busy)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic [1:0] sel;
    logic wr_en;
    logic [4:0] waddr;
    logic [31:0] pc, addr, sdata, rdata;
    logic ebreak;
  } txn_t;
  txn_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
  endfunction

  function automatic logic [31:0] load_val(input txn_t t);
    longint unsigned v, span;
    int off;
    off = int'(t.addr % 4);
    span = 64'd1 << (8 * nbytes(t.f3));
    v = (64'(t.rdata) >> (8 * off)) % span;
    if (t.f3 != 3'd4 && t.f3 != 3'd5 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_result(input txn_t t);
    case (t.sel)
      2'd0: return 32'd0;
      2'd1: return t.pc + 32'd4;
      2'd2: return t.addr;
      default: return load_val(t);
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input txn_t t);
    return 4'(((1 << nbytes(t.f3)) - 1) << (t.addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input txn_t t);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = t.sdata[8*(i % nbytes(t.f3)) +: 8];
    return w;
  endfunction

  function automatic txn_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [1:0] sel,
                              input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata);
    txn_t t;
    t.op = op; t.f3 = f3; t.sel = sel; t.wr_en = op != 2'd2;
    t.waddr = 5'($urandom); t.pc = $urandom; t.addr = addr;
    t.sdata = sdata; t.rdata = rdata; t.ebreak = 1'($urandom);
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int k;
    k = int'($urandom_range(0, 3));
    t = mk(2'd0, 3'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom, $urandom);
    if (k < 2) t.wr_en = 1'($urandom);
    else if (k == 2) begin
      t.op = 2'd1; t.f3 = 3'($urandom_range(0, 6)); t.sel = 2'd3; t.wr_en = 1'b1;
    end else begin
      t.op = 2'd2; t.f3 = 3'($urandom_range(0, 2)); t.sel = 2'd0; t.wr_en = 1'b0;
    end
    if (t.op != 2'd0) t.addr = t.addr & ~32'(nbytes(t.f3) - 1);
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input txn_t t);
    exe_to_mem_valid = 1'b1;
    exe_pc = t.pc; exe_alu_result = t.addr; exe_store_data = t.sdata;
    exe_mem_op = t.op; exe_funct3 = t.f3; exe_rf_wr_sel = t.sel;
    exe_rf_wr_en = t.wr_en; exe_reg_waddr = t.waddr; exe_inst_ebreak = t.ebreak;
    q.push_back(t);
  endtask

  // Drives the memory side for the op at the head of the queue: rdy stall cycles, then rsp wait cycles
  task automatic serve(input int rdy, input int rsp);
    txn_t t;
    t = q[0];
    if (t.op == 2'd1 || t.op == 2'd2) begin
      for (int i = 0; i <= rdy; i++) begin
        check1("req_valid", dmem_req_valid, 1'b1);
        check1("req_we", dmem_req_we, t.op == 2'd2);
        check("req_addr", dmem_req_addr, t.addr & ~32'd3);
        if (t.op == 2'd2) begin
          check("req_wstrb", 32'(dmem_req_wstrb), 32'(exp_strb(t)));
          check("req_wdata", dmem_req_wdata, exp_wdata(t));
        end
        check1("busy_req", bypass_busy, t.op == 2'd1);
        check1("wb_valid_req", mem_to_wb_valid, 1'b0);
        check1("allow_req", mem_allow_in, 1'b0);
        dmem_req_ready = i == rdy;
        dmem_rsp_valid = i != rdy && $urandom_range(0, 1) == 1;
        dmem_rsp_rdata = $urandom;
        tick;
      end
      dmem_req_ready = 1'b0;
      for (int j = 0; j <= rsp; j++) begin
        check1("req_valid_wait", dmem_req_valid, 1'b0);
        check1("busy_wait", bypass_busy, t.op == 2'd1);
        check1("wb_valid_wait", mem_to_wb_valid, 1'b0);
        dmem_rsp_valid = j == rsp;
        dmem_rsp_rdata = (j == rsp) ? t.rdata : $urandom;
        tick;
      end
      dmem_rsp_valid = 1'b0;
      dmem_rsp_rdata = $urandom;
    end
  endtask

  task automatic drain(input int stall);
    txn_t t;
    logic [31:0] r;
    t = q[0];
    r = exp_result(t);
    for (int i = 0; i < stall; i++) begin
      wb_allow_in = 1'b0;
      #1;
      check1("stall_valid", mem_to_wb_valid, 1'b1);
      check("stall_result", mem_to_wb_result, r);
      check1("stall_no_req", dmem_req_valid, 1'b0);
      check1("stall_allow", mem_allow_in, 1'b0);
      tick;
    end
    wb_allow_in = 1'b1;
    #1;
    check1("wb_valid", mem_to_wb_valid, 1'b1);
    check("wb_result", mem_to_wb_result, r);
    check1("wb_wr_en", mem_to_wb_rf_wr_en, t.wr_en);
    check("wb_waddr", 32'(mem_to_wb_reg_waddr), 32'(t.waddr));
    check("wb_pc", mem_to_wb_pc, t.pc);
    check1("wb_ebreak", mem_to_wb_ebreak, t.ebreak);
    check1("byp_wr_en", bypass_wr_en, t.wr_en);
    check("byp_waddr", 32'(bypass_waddr), 32'(t.waddr));
    check("byp_data", bypass_data, r);
    check1("byp_busy_done", bypass_busy, 1'b0);
    check1("no_req_done", dmem_req_valid, 1'b0);
    check1("allow_done", mem_allow_in, 1'b1);
    tick;
    void'(q.pop_front());
  endtask

  task automatic run_one(input txn_t t, input int rdy, input int rsp, input int stall);
    present(t);
    #1;
    check1("allow_idle", mem_allow_in, 1'b1);
    tick;
    exe_to_mem_valid = 1'b0;
    serve(rdy, rsp);
    drain(stall);
    check1("empty_after", mem_valid, 1'b0);
  endtask

  initial begin
    txn_t t;
    tick;
    tick;
    check1("rst_mem_valid", mem_valid, 1'b0);
    check1("rst_req_valid", dmem_req_valid, 1'b0);
    check1("rst_wb_valid", mem_to_wb_valid, 1'b0);
    check1("rst_byp_wr_en", bypass_wr_en, 1'b0);
    check1("rst_byp_busy", bypass_busy, 1'b0);
    rst = 1'b0;
    tick;
    check1("idle_allow", mem_allow_in, 1'b1);
    // ALU result passes straight through
    run_one(mk(2'd0, 3'd0, 2'd2, 32'h1234, 32'h0, 32'h0), 0, 0, 0);
    t = mk(2'd0, 3'd0, 2'd1, 32'h0, 32'h0, 32'h0);
    t.pc = 32'hffff_fffc;
    run_one(t, 0, 0, 0);
    run_one(mk(2'd0, 3'd0, 2'd0, 32'h55aa, 32'h0, 32'h0), 0, 0, 1);
    // LB sign-extension at the top lane, minimum latency
    run_one(mk(2'd1, 3'd0, 2'd3, 32'h1003, 32'h0, 32'h80ff_ff00), 0, 0, 0);
    run_one(mk(2'd1, 3'd4, 2'd3, 32'h1003, 32'h0, 32'h80ff_ff00), 1, 2, 0);
    run_one(mk(2'd1, 3'd1, 2'd3, 32'h1002, 32'h0, 32'h8001_7fff), 0, 1, 0);
    run_one(mk(2'd1, 3'd5, 2'd3, 32'h1002, 32'h0, 32'h8001_7fff), 2, 0, 0);
    // SH with a stalled request channel
    run_one(mk(2'd2, 3'd1, 2'd0, 32'h2002, 32'h0000_abcd, 32'h0), 3, 0, 0);
    run_one(mk(2'd2, 3'd0, 2'd0, 32'h2001, 32'h1234_56ef, 32'h0), 0, 0, 0);
    // LW held in DONE by WB while a second LW waits, then captured straight into a request
    present(mk(2'd1, 3'd2, 2'd3, 32'h3008, 32'h0, 32'hcafe_f00d));
    tick;
    exe_to_mem_valid = 1'b0;
    serve(0, 0);
    present(mk(2'd1, 3'd2, 2'd3, 32'h300c, 32'h0, 32'h1357_9bdf));
    drain(2);
    exe_to_mem_valid = 1'b0;
    serve(0, 0);
    drain(0);
    check1("b2b_empty", mem_valid, 1'b0);
    // Reset during REQ drops the request without a clock edge
    present(mk(2'd1, 3'd2, 2'd3, 32'h4000, 32'h0, 32'h1111_2222));
    tick;
    exe_to_mem_valid = 1'b0;
    check1("pre_rst_req", dmem_req_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("rst_req_drop", dmem_req_valid, 1'b0);
    check1("rst_async_valid", mem_valid, 1'b0);
    check1("rst_async_busy", bypass_busy, 1'b0);
    q.delete();
    tick;
    rst = 1'b0;
    // Reset during WAIT, then a late response that must be dropped
    present(mk(2'd1, 3'd2, 2'd3, 32'h4004, 32'h0, 32'hdead_beef));
    tick;
    exe_to_mem_valid = 1'b0;
    dmem_req_ready = 1'b1;
    tick;
    dmem_req_ready = 1'b0;
    check1("wait_busy", bypass_busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h0bad_0bad;
    tick;
    dmem_rsp_valid = 1'b0;
    check1("late_rsp_valid", mem_valid, 1'b0);
    check1("late_rsp_wb", mem_to_wb_valid, 1'b0);
    check1("late_rsp_busy", bypass_busy, 1'b0);
    check1("late_rsp_req", dmem_req_valid, 1'b0);
    q.delete();
    run_one(mk(2'd1, 3'd2, 2'd3, 32'h4008, 32'h0, 32'h2468_ace0), 0, 0, 0);
    for (int n = 0; n < 150; n++)
      run_one(rand_txn(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Parametrised MEM pipeline stage with a real data-memory handshake. It replaces the zero-wait MEM stage that took load data already resolved in EXE. It issues load/store requests on a valid/ready request channel, waits any number of cycles for the response, aligns and sign-extends load data, and builds store byte-strobes. It sits between EXE and WB and drives the MEM-to-ID bypass with a busy flag for loads still in flight.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
PC_WIDTH, 32, PC width.
RADDR_W, 5, register-file address width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
exe_to_mem_valid  in  1  EXE holds a valid instruction
mem_allow_in  out  1  stage can accept this cycle
wb_allow_in  in  1  WB can accept
mem_to_wb_valid  out  1  result valid toward WB
exe_pc  in  PC_WIDTH  instruction PC
exe_alu_result  in  XLEN  ALU result / effective address
exe_store_data  in  XLEN  rs2 value, unaligned
exe_mem_op  in  2  00 none, 01 load, 10 store
exe_funct3  in  3  size/sign encoding (RV)
exe_rf_wr_sel  in  2  00 zero, 01 pc+4, 10 alu, 11 load
exe_rf_wr_en  in  1  register write enable
exe_reg_waddr  in  RADDR_W  destination register
exe_inst_ebreak  in  1  ebreak marker
dmem_req_valid  out  1  request valid
dmem_req_ready  in  1  memory accepts request
dmem_req_we  out  1  1 = store
dmem_req_addr  out  XLEN  address, low lane bits cleared
dmem_req_wstrb  out  XLEN/8  byte strobes
dmem_req_wdata  out  XLEN  lane-replicated store data
dmem_rsp_valid  in  1  response valid, one cycle per request
dmem_rsp_rdata  in  XLEN  full-word read data
mem_to_wb_pc  out  PC_WIDTH  PC to WB
mem_to_wb_result  out  XLEN  final writeback value
mem_to_wb_rf_wr_en  out  1  write enable to WB
mem_to_wb_reg_waddr  out  RADDR_W  destination register to WB
mem_to_wb_ebreak  out  1  ebreak marker to WB
mem_valid  out  1  stage occupied
bypass_wr_en  out  1  forwarding: write enable
bypass_waddr  out  RADDR_W  forwarding: destination register
bypass_data  out  XLEN  forwarding: value
bypass_busy  out  1  load result not yet available; ID must stall on a match

Behaviour:
- Reset, asynchronous: mem_valid=0, FSM=IDLE, dmem_req_valid=0, mem_to_wb_valid=0, bypass_wr_en=0, bypass_busy=0. Payload registers are not reset.
- Capture: mem_allow_in = !mem_valid | (ready_go & wb_allow_in). When mem_allow_in, mem_valid <= exe_to_mem_valid; the payload latches only if exe_to_mem_valid.
- Non-memory op: ready_go=1 while valid. Zero added latency. The FSM stays IDLE.
- Memory op FSM:
  - REQ: entered on capture of a load or store. dmem_req_valid=1 with stable address, strobes and data until dmem_req_ready. Accept → WAIT.
  - WAIT: on dmem_rsp_valid, register rdata → DONE. Stores also wait for an ack response.
  - DONE: ready_go=1. When wb_allow_in, return to IDLE; if a new memory op is captured in the same cycle, go straight to REQ.
  - Minimum load latency: request accepted in the entry cycle N, response at N+1, mem_to_wb_valid at N+2.
- dmem_rsp_valid outside WAIT is ignored. A response arriving after a reset is dropped.
- Lane index = addr[log2(XLEN/8)-1:0].
- Loads: extract byte/half/word/double at the lane index.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend to XLEN.
  - LD/LWU are legal only when XLEN=64; otherwise they are treated as LW.
- Stores: data is replicated across lanes. wstrb is a size mask shifted by the lane index, e.g. SH at offset 2, XLEN=32 → 4'b1100.
- Result mux follows rf_wr_sel. pc+4 is computed at PC_WIDTH and zero-extended to XLEN.
- Bypass:
  - bypass_wr_en = mem_valid & rf_wr_en.
  - bypass_busy = mem_valid & load & FSM!=DONE.
  - bypass_data = final result, valid only when bypass_busy=0.
- WB stall in DONE holds all outputs stable. No second request is issued.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- Defined: an access not naturally aligned to its size issues no request. The stage goes IDLE→DONE in one cycle, forces rf_wr_en=0, and asserts an extra output mem_to_wb_misalign=1 with the faulting address in mem_to_wb_result.
- Undefined: no check is made, the port is absent, and the lane bits are used as computed (the access may cross a word, in which case the data is undefined).

Decomposition:
- Package mem_lsu_pkg holds:
  - mem_op and rf_wr_sel encodings
  - funct3 load/store constants
  - FSM state enum (IDLE, REQ, WAIT, DONE)
  - lane-width localparams
- Sub-module load_align: combinational rdata + funct3 + lane → aligned, extended result. It is reused later by the AMO unit.

Test Plan:
- ALU op (rf_wr_sel=10, result 0x1234), wb_allow_in=1 → mem_to_wb_valid the cycle after capture, result 0x1234, dmem_req_valid never asserted.
- LB at addr 0x1003, rdata 0x80FF_FF00, req_ready=1, rsp next cycle → result 0xFFFF_FF80 at N+2; bypass_busy=1 for cycles N and N+1.
- SH at addr 0x2002, data 0x0000_ABCD, req_ready held low 3 cycles → req fields stable for 4 cycles; wstrb=4'b1100, wdata=0xABCD_ABCD; mem_allow_in=0 until DONE with wb_allow_in=1.
- LW in DONE, wb_allow_in=0 for 2 cycles → outputs held and no new request; back-to-back LW is captured on release and enters REQ directly.
- rst asserted while in WAIT, then a rsp_valid arrives → the response is ignored, mem_valid=0, and dmem_req_valid drops asynchronously.
- With MEM_MISALIGN_TRAP_EN defined: LW at 0x1002 → no request, mem_to_wb_misalign=1, rf_wr_en=0, result=0x1002.
